// File: rtl/sys_pkg.sv
// Shared definitions for the systolic-array drain path: element width,
// column count and the row record handed to the unified-buffer writer.
package sys_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int MAX_COLS   = 2;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data_1;
    logic [DATA_WIDTH-1:0] data_2;
    logic [MAX_COLS-1:0]   mask;
  } row_t;

  // Column sizes above the array width saturate at MAX_COLS.
  function automatic logic [1:0] clamp_cols(input logic [15:0] size);
    return (size > 16'(MAX_COLS)) ? 2'(MAX_COLS) : size[1:0];
  endfunction
endpackage

// File: rtl/sys_row_fifo.sv
// Synchronous first-word fall-through FIFO of row_t. Pointers carry one
// extra wrap bit so full and empty are distinguishable.
module sys_row_fifo
  import sys_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic push,
  input  row_t push_data,
  input  logic pop,
  output logic full,
  output logic empty,
  output row_t head
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  row_t        r_mem [DEPTH];
  logic        w_do_push;
  logic        w_do_pop;

  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = pop && !empty && !clear;
  assign w_do_push = push && (!full || w_do_pop) && !clear;
  assign head      = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end
endmodule

// File: rtl/sys_output_collector.sv
// Collects the skewed column outputs of the 2x2 systolic array, re-aligns them
// into rows and buffers them for the unified-buffer write path (valid/ready).
module sys_output_collector
  import sys_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] col_data_in_1,
  input  logic [DATA_WIDTH-1:0] col_data_in_2,
  input  logic                  col_valid_in_1,
  input  logic                  col_valid_in_2,
  input  logic [15:0]           col_size_in,
  input  logic                  col_size_valid_in,
  input  logic                  clear_in,
  output logic [DATA_WIDTH-1:0] row_data_out_1,
  output logic [DATA_WIDTH-1:0] row_data_out_2,
  output logic [1:0]            row_mask_out,
  output logic                  row_valid_out,
  input  logic                  row_ready_in,
  output logic [15:0]           row_count_out,
  output logic                  overflow_out,
  output logic                  skew_err_out
);
  // Handshake: a row transfers on any cycle with row_valid_out && row_ready_in;
  // the head row stays stable while valid is high and ready is low.
  logic [1:0]            r_active_cols;
  logic                  r_pending;
  logic [DATA_WIDTH-1:0] r_skew;
  logic [15:0]           r_row_count;
  logic                  r_overflow;
  logic                  r_skew_err;
  logic                  w_form_1, w_form_2, w_col2_err, w_form;
  logic                  w_pop, w_push, w_full, w_empty;
  row_t                  w_row, w_head;

  assign w_form_1   = !clear_in && (r_active_cols == 2'd1) && col_valid_in_1;
  assign w_form_2   = !clear_in && (r_active_cols == 2'd2) && col_valid_in_2 && r_pending;
  assign w_col2_err = !clear_in && (r_active_cols == 2'd2) && col_valid_in_2 && !r_pending;
  assign w_form     = w_form_1 || w_form_2;
  assign w_pop      = !w_empty && row_ready_in;
  assign w_push     = w_form && (!w_full || w_pop);

  always_comb begin
    w_row = '0;
    if (w_form_1) begin
      w_row.data_1 = col_data_in_1;
      w_row.mask   = 2'b01;
    end else begin
      w_row.data_1 = r_skew;
      w_row.data_2 = col_data_in_2;
      w_row.mask   = 2'b11;
    end
  end

  // Skew register: a column-1 load and a column-2 row completion may share an
  // edge; the row is built from the old contents while the new one loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active_cols <= '0;
      r_pending     <= 1'b0;
      r_skew        <= '0;
    end else if (clear_in) begin
      r_pending <= 1'b0;
    end else if (col_size_valid_in) begin
      r_active_cols <= clamp_cols(col_size_in);
      r_pending     <= 1'b0;
    end else if ((r_active_cols == 2'd2) && col_valid_in_1) begin
      r_pending <= 1'b1;
      r_skew    <= col_data_in_1;
    end else if (w_form_2) begin
      r_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row_count <= '0;
      r_overflow  <= 1'b0;
      r_skew_err  <= 1'b0;
    end else if (clear_in) begin
      r_row_count <= '0;
      r_overflow  <= 1'b0;
      r_skew_err  <= 1'b0;
    end else begin
      if (w_pop)                        r_row_count <= r_row_count + 16'd1;
      if (w_form && w_full && !w_pop)   r_overflow  <= 1'b1;
      if (w_col2_err)                   r_skew_err  <= 1'b1;
    end
  end

  sys_row_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear_in),
    .push      (w_push),
    .push_data (w_row),
    .pop       (w_pop),
    .full      (w_full),
    .empty     (w_empty),
    .head      (w_head)
  );

  // Stale memory contents are hidden while the FIFO is empty.
  assign row_valid_out  = !w_empty;
  assign row_data_out_1 = w_empty ? '0 : w_head.data_1;
  assign row_data_out_2 = w_empty ? '0 : w_head.data_2;
  assign row_mask_out   = w_empty ? '0 : w_head.mask;
  assign row_count_out  = r_row_count;
  assign overflow_out   = r_overflow;
  assign skew_err_out   = r_skew_err;
endmodule

// File: tb/tb_sys_output_collector.sv
// Bench for sys_output_collector: directed scenarios plus random traffic,
// checked against a row-level reference model through an expected queue.
module tb_sys_output_collector;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] col_data_in_1 = '0, col_data_in_2 = '0;
  logic        col_valid_in_1 = 1'b0, col_valid_in_2 = 1'b0;
  logic [15:0] col_size_in = '0;
  logic        col_size_valid_in = 1'b0;
  logic        clear_in = 1'b0;
  logic [15:0] row_data_out_1, row_data_out_2;
  logic [1:0]  row_mask_out;
  logic        row_valid_out;
  logic        row_ready_in = 1'b0;
  logic [15:0] row_count_out;
  logic        overflow_out, skew_err_out;

  int checks = 0;
  int errors = 0;

  // Reference model state: rows waiting in the buffer, in delivery order.
  logic [33:0] exp_q[$];
  int          m_act = 0;
  logic        m_pend = 1'b0;
  logic [15:0] m_skew = '0;
  int          m_occ = 0;
  logic [15:0] m_count = '0;
  logic        m_ovf = 1'b0;
  logic        m_err = 1'b0;

  sys_output_collector #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .col_data_in_1(col_data_in_1), .col_data_in_2(col_data_in_2),
    .col_valid_in_1(col_valid_in_1), .col_valid_in_2(col_valid_in_2),
    .col_size_in(col_size_in), .col_size_valid_in(col_size_valid_in),
    .clear_in(clear_in),
    .row_data_out_1(row_data_out_1), .row_data_out_2(row_data_out_2),
    .row_mask_out(row_mask_out), .row_valid_out(row_valid_out),
    .row_ready_in(row_ready_in), .row_count_out(row_count_out),
    .overflow_out(overflow_out), .skew_err_out(skew_err_out)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // reference model: applies the row rules once per clock edge
  initial begin
    logic        formed, pop, drop;
    logic [33:0] row;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_act = 0; m_pend = 1'b0; m_skew = '0; m_occ = 0;
        m_count = '0; m_ovf = 1'b0; m_err = 1'b0; exp_q.delete();
      end else if (clear_in) begin
        m_pend = 1'b0; m_occ = 0; m_count = '0; m_ovf = 1'b0; m_err = 1'b0;
        exp_q.delete();
      end else begin
        formed = 1'b0; row = '0;
        pop = (m_occ > 0) && row_ready_in;
        if (m_act == 1 && col_valid_in_1) begin
          formed = 1'b1; row = {col_data_in_1, 16'h0000, 2'b01};
        end
        if (m_act == 2 && col_valid_in_2) begin
          if (m_pend) begin formed = 1'b1; row = {m_skew, col_data_in_2, 2'b11}; end
          else m_err = 1'b1;
        end
        drop = formed && (m_occ == DEPTH) && !pop;
        if (pop) begin m_occ--; m_count++; end
        if (formed) begin
          if (drop) m_ovf = 1'b1;
          else begin m_occ++; exp_q.push_back(row); end
        end
        if (col_size_valid_in) begin
          m_act = (col_size_in > 16'd2) ? 2 : int'(col_size_in);
          m_pend = 1'b0;
        end else if (m_act == 2 && col_valid_in_1) begin
          m_pend = 1'b1; m_skew = col_data_in_1;
        end else if (formed && m_act == 2) begin
          m_pend = 1'b0;
        end
      end
    end
  end

  // monitor / scoreboard: samples on the falling edge
  initial begin
    logic [33:0] e;
    forever begin
      @(negedge clk);
      chk("row_valid", row_valid_out, m_occ > 0);
      chk("row_count", row_count_out, m_count);
      chk("overflow", overflow_out, m_ovf);
      chk("skew_err", skew_err_out, m_err);
      if (rst) chk("reset_row", {row_data_out_1, row_data_out_2, row_mask_out}, 34'h0);
      if (row_valid_out && row_ready_in) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_row", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("row_data", {row_data_out_1, row_data_out_2, row_mask_out}, e);
        end
      end
    end
  end

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic drive(input logic v1, input logic [15:0] d1,
                       input logic v2, input logic [15:0] d2, input logic rdy);
    col_valid_in_1 = v1; col_data_in_1 = d1;
    col_valid_in_2 = v2; col_data_in_2 = d2;
    row_ready_in   = rdy;
    @(posedge clk); #1;
    col_size_valid_in = 1'b0;
    clear_in = 1'b0;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) drive(1'b0, 16'h0, 1'b0, 16'h0, rdy);
  endtask

  task automatic set_size(input logic [15:0] n);
    col_size_in = n; col_size_valid_in = 1'b1;
    idle(1, row_ready_in);
  endtask

  task automatic do_clear();
    clear_in = 1'b1;
    idle(1, row_ready_in);
  endtask

  initial begin
    logic prev_v1;
    logic v1, v2;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_count", row_count_out, 16'h0);
    chk("reset_valid", row_valid_out, 1'b0);

    // back-to-back two-column rows
    set_size(16'd2);
    drive(1'b1, 16'h0011, 1'b0, 16'h0,    1'b1);
    drive(1'b1, 16'h0021, 1'b1, 16'h0012, 1'b1);
    drive(1'b0, 16'h0,    1'b1, 16'h0022, 1'b1);
    idle(3, 1'b1);
    chk("t1_count", row_count_out, 16'd2);

    // single-column rows, column 2 ignored
    set_size(16'd1);
    drive(1'b1, 16'h00AA, 1'b1, 16'h1234, 1'b1);
    drive(1'b1, 16'h00BB, 1'b0, 16'h0,    1'b1);
    drive(1'b0, 16'h0,    1'b1, 16'h0005, 1'b1);
    idle(3, 1'b1);
    chk("t2_skew_err", skew_err_out, 1'b0);
    chk("t2_count", row_count_out, 16'd4);

    // overflow: five rows into four slots with ready low, then drain
    set_size(16'd2);
    for (int i = 0; i < 6; i++)
      drive(i < 5, 16'h0100 + 16'(i), i > 0, 16'h0200 + 16'(i) - 16'h1, 1'b0);
    idle(1, 1'b0);
    chk("t3_overflow", overflow_out, 1'b1);
    idle(6, 1'b1);
    chk("t3_count", row_count_out, 16'd8);
    do_clear();

    // full FIFO with simultaneous push and pop
    for (int i = 0; i < 5; i++)
      drive(i < 4, 16'h0300 + 16'(i), i > 0, 16'h0400 + 16'(i) - 16'h1, 1'b0);
    idle(1, 1'b0);
    drive(1'b1, 16'h0333, 1'b0, 16'h0,    1'b0);
    drive(1'b0, 16'h0,    1'b1, 16'h0444, 1'b1);
    idle(1, 1'b0);
    chk("t4_overflow", overflow_out, 1'b0);
    idle(6, 1'b1);
    chk("t4_count", row_count_out, 16'd5);

    // orphan column-2 element, then clear
    drive(1'b0, 16'h0, 1'b1, 16'h0077, 1'b1);
    idle(2, 1'b1);
    chk("t5_skew_err", skew_err_out, 1'b1);
    chk("t5_valid", row_valid_out, 1'b0);
    do_clear();
    chk("t5_clr_err", skew_err_out, 1'b0);
    chk("t5_clr_count", row_count_out, 16'd0);

    // reset between column 1 and column 2
    drive(1'b1, 16'h0055, 1'b0, 16'h0, 1'b1);
    rst = 1'b1;
    #1;
    chk("t6_rst_flags", {row_valid_out, overflow_out, skew_err_out, row_count_out}, 19'h0);
    @(posedge clk); #1 rst = 1'b0;
    drive(1'b0, 16'h0, 1'b1, 16'h0066, 1'b1);
    set_size(16'd2);
    drive(1'b1, 16'h0061, 1'b0, 16'h0,    1'b1);
    drive(1'b0, 16'h0,    1'b1, 16'h0062, 1'b1);
    idle(3, 1'b1);
    chk("t6_count", row_count_out, 16'd1);
    chk("t6_skew_err", skew_err_out, 1'b0);

    // random traffic with occasional size changes, clears and orphan valids
    prev_v1 = 1'b0;
    for (int c = 0; c < 800; c++) begin
      if (c % 160 == 0) begin
        case ($urandom_range(0, 4))
          0: col_size_in = 16'd0;
          1: col_size_in = 16'd1;
          2: col_size_in = 16'd2;
          3: col_size_in = 16'd3;
          default: col_size_in = 16'd9;
        endcase
        col_size_valid_in = 1'b1;
      end
      if ($urandom_range(0, 99) == 0) clear_in = 1'b1;
      v1 = ($urandom_range(0, 1) == 1);
      v2 = prev_v1 ^ ($urandom_range(0, 19) == 0);
      prev_v1 = v1;
      drive(v1, 16'($urandom), v2, 16'($urandom), $urandom_range(0, 9) < 6);
    end
    idle(8, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sys_output_collector.md
Name: sys_output_collector

Overview:
- Drain-side partner of the 2x2 systolic array.
- Captures the skewed column outputs leaving the bottom edge of the array (psum data and valid for column 1 and column 2).
- De-skews them into complete rows and buffers the rows in a small FIFO.
- Hands the rows to the unified-buffer write path over a valid/ready handshake. The array cannot stall, so the FIFO absorbs downstream backpressure and flags any loss.

Parameters:
- DATA_WIDTH, 16: width of one psum element.
- FIFO_DEPTH, 4: number of complete rows buffered; power of two, at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- col_data_in_1  in  DATA_WIDTH  column-1 psum from the bottom of the array.
- col_data_in_2  in  DATA_WIDTH  column-2 psum from the bottom of the array.
- col_valid_in_1  in  1  column-1 psum valid.
- col_valid_in_2  in  1  column-2 psum valid; lags column 1 by exactly 1 cycle for the same row.
- col_size_in  in  16  number of active columns, same encoding as ub_rd_col_size_in.
- col_size_valid_in  in  1  load col_size_in.
- clear_in  in  1  synchronous flush.
- row_data_out_1  out  DATA_WIDTH  row element for column 1.
- row_data_out_2  out  DATA_WIDTH  row element for column 2; 0 when masked.
- row_mask_out  out  2  per-column valid mask of the head row.
- row_valid_out  out  1  head row available.
- row_ready_in  in  1  downstream accepts the head row.
- row_count_out  out  16  rows delivered (handshakes).
- overflow_out  out  1  sticky: at least one row was dropped.
- skew_err_out  out  1  sticky: column-2 valid arrived with no pending column-1 element.

Behaviour:
Reset values
- All outputs 0.
- active_cols = 0, skew register empty, FIFO empty.

Column-count register
- When col_size_valid_in is high, active_cols <= min(col_size_in, 2) at the next edge.
- On the same edge, any pending skew element is discarded.
- With active_cols = 0, all column input is ignored.

active_cols = 1
- Each col_valid_in_1 cycle forms a row: mask = 01, data_2 = 0.
- col_valid_in_2 is ignored.

active_cols = 2
- col_valid_in_1 loads the skew register (data plus pending flag).
- col_valid_in_2 with pending = 1 forms the row {skew, col_data_in_2}, mask = 11, and clears pending.
- The skew register is single-entry. Column 1 of row n+1 and column 2 of row n in the same cycle is the normal back-to-back case: the skew register reloads on that edge while row n is formed from the old contents.
- col_valid_in_2 with pending = 0: set skew_err_out, drop the element.

Latency
- A row is written to the FIFO at the edge ending the cycle of its last column valid.
- row_valid_out rises in the next cycle: first-word fall-through with registered status.
- 2-column row: col1 valid at cycle t, col2 valid at t+1, row_valid_out at t+2.

Handshake
- A transfer occurs on a cycle where row_valid_out and row_ready_in are both high.
- The head is held stable while row_valid_out is high and row_ready_in is low.
- row_count_out increments by 1 per transfer and wraps 0xFFFF -> 0.

FIFO boundaries
- Push into a full FIFO with no pop in the same cycle: row dropped, overflow_out set.
- Full FIFO with push and pop in the same cycle: both succeed, occupancy unchanged.
- Empty FIFO: pop is impossible because row_valid_out = 0. A push into an empty FIFO is visible the next cycle (no bypass).

clear_in (highest priority after reset)
- Empties the FIFO and skew register.
- Zeros row_count_out, overflow_out and skew_err_out.
- Keeps active_cols.
- Column valids arriving in a clear cycle are discarded.

Reset mid-operation
- Immediate return to reset values. Partial rows are lost without setting any flag.

Decomposition:
- Package sys_pkg:
  - DATA_WIDTH constant.
  - MAX_COLS = 2.
  - typedef row_t struct {data_1, data_2, mask[1:0]}, shared with the unified-buffer write path.
- Sub-module sys_row_fifo: generic synchronous FIFO of row_t.
  - Parameter: DEPTH.
  - Ports: push, pop, full, empty, head.
  - Pointers one bit wider than log2(DEPTH) for the full/empty distinction.
- Top level holds the column-count register, skew register, row forming, counters and sticky flags.

Test Plan:
- Load col_size = 2. Drive col1 = 0x0011 at t, then col1 = 0x0021 with col2 = 0x0012 at t+1, then col2 = 0x0022 at t+2, with ready held high. Expect rows {0x0011,0x0012} at t+2 and {0x0021,0x0022} at t+3, both mask 11; row_count = 2.
- Load col_size = 1. Drive col1 = 0x00AA and 0x00BB on consecutive cycles while toggling col2 valid. Expect rows {0x00AA,0} and {0x00BB,0}, mask 01; skew_err stays 0.
- Hold ready low with col_size = 2 and push 5 rows. Expect 4 rows buffered, the 5th dropped, overflow = 1. Then raise ready: the first 4 rows drain in order and row_count = 4.
- With the FIFO full, assert ready and complete a new row in the same cycle. Expect no overflow and occupancy to stay at 4.
- With col_size = 2, drive col2 valid with no preceding col1. Expect skew_err = 1 and no row. Then assert clear: all flags and row_count return to 0.
- Assert rst mid-row, after col1 and before col2. Expect all outputs 0, then a clean first row after active_cols is reloaded.
